// File: rtl/core_config_pkg.sv
// core_config_pkg: shared core configuration types and constants.
// Holds the stage_link state encoding, the link depth and a saturating
// counter helper used by optional statistics logic.
package core_config_pkg;

  // Occupancy states of the two-entry stage link.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_link_state_t;

  // Number of words a stage link can hold (head plus skid entry).
  localparam int STAGE_LINK_DEPTH = 2;

  // Width of the optional statistics counters.
  localparam int STAT_CNT_W = 32;

  // Increment a statistics counter, holding it at all-ones once saturated.
  function automatic logic [STAT_CNT_W-1:0] sat_inc(input logic [STAT_CNT_W-1:0] val);
    logic [STAT_CNT_W-1:0] res;
    if (val == {STAT_CNT_W{1'b1}}) begin
      res = val;
    end else begin
      res = val + {{(STAT_CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage : core_config_pkg

// File: rtl/en_edge.sv
// en_edge: turns a multi-cycle clock-enable level into a one-cycle strobe.
// The strobe fires on the first clk cycle in which en is seen high after
// having been low. It is held low while rst_n is asserted so that nothing
// downstream can move during reset even if en is already high.
module en_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  logic en_q_r;

  // Remember the enable level from the previous clk cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q_r <= 1'b0;
    end else begin
      en_q_r <= en;
    end
  end

  // Rising-edge detect, gated by reset so the strobe is quiet in reset.
  always_comb begin
    tick = en & ~en_q_r & rst_n;
  end

endmodule : en_edge

// File: rtl/stage_link.sv
// stage_link: two-entry pipeline link whose transfers are paced by the core
// clock-enable. Words move across the valid/ready handshake only on the
// one-cycle tick derived from clk_en; the skid entry absorbs one word of
// downstream backpressure so an accepted word is never lost.
// Optional feature macro: STAGE_LINK_STATS_EN adds saturating xfer_cnt and
// stall_cnt output counters.
module stage_link
  import core_config_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             tick
`ifdef STAGE_LINK_STATS_EN
  ,
  output logic [STAT_CNT_W-1:0] xfer_cnt,
  output logic [STAT_CNT_W-1:0] stall_cnt
`endif
);

  stage_link_state_t state_r;
  logic [WIDTH-1:0]  head_r;
  logic [WIDTH-1:0]  skid_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              tick_s;
  logic              push_s;
  logic              pop_s;

  en_edge u_en_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (clk_en),
    .tick  (tick_s)
  );

  // Handshake qualification: nothing moves unless the tick is present.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (tick_s) begin
      push_s = in_valid & in_ready_r;
      pop_s  = out_valid_r & out_ready;
    end else begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end
  end

  // Occupancy FSM with storage and registered ready/valid; flush wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      head_r      <= {WIDTH{1'b0}};
      skid_r      <= {WIDTH{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            head_r      <= in_data;
            state_r     <= ONE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b1;
          end
        end
        ONE: begin
          if (push_s && pop_s) begin
            head_r <= in_data;
          end else if (push_s) begin
            skid_r      <= in_data;
            state_r     <= FULL;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b1;
          end else if (pop_s) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        FULL: begin
          if (pop_s) begin
            head_r      <= skid_r;
            state_r     <= ONE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Drive ports straight from the state-decoded registers.
  always_comb begin
    in_ready  = in_ready_r;
    out_valid = out_valid_r;
    out_data  = head_r;
    tick      = tick_s;
  end

`ifdef STAGE_LINK_STATS_EN
  logic [STAT_CNT_W-1:0] xfer_cnt_r;
  logic [STAT_CNT_W-1:0] stall_cnt_r;

  // Saturating transfer and stall counters; flush leaves them intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_r  <= {STAT_CNT_W{1'b0}};
      stall_cnt_r <= {STAT_CNT_W{1'b0}};
    end else begin
      if (pop_s && !flush) begin
        xfer_cnt_r <= sat_inc(xfer_cnt_r);
      end
      if (tick_s && out_valid_r && !out_ready) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
    end
  end

  // Expose the counters.
  always_comb begin
    xfer_cnt  = xfer_cnt_r;
    stall_cnt = stall_cnt_r;
  end
`endif

endmodule : stage_link
